// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus interface unit: strobe/status bit positions,
// response status codes and the handshake state encoding.
package cpu_bus_pkg;

   localparam int CTRL_RD  = 0;
   localparam int CTRL_WR  = 1;
   localparam int STAT_ACK = 0;
   localparam int STAT_ERR = 1;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_BUS     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RESP    = 2'd3
   } bus_state_e;

endpackage

// File: rtl/cpu_bus_unit.sv
// Bus interface unit: runs one four-phase strobe/acknowledge transaction per CPU
// request and returns a single-cycle response with a status code.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | req_ready high, waiting for req_valid
// ST_STROBE  | RD or WR strobe held, waiting for ACK (bounded by TIMEOUT)
// ST_RELEASE | strobe dropped, waiting for ACK to return low (bounded)
// ST_RESP    | resp_valid pulse, back to IDLE next cycle
module cpu_bus_unit #(
   parameter int word_width = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [word_width-1:0] req_addr,
   input  logic [word_width-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [word_width-1:0] resp_rdata,
   output logic [1:0]            resp_err,
   output logic [word_width-1:0] mobo_ctrl,
   input  logic [word_width-1:0] mobo_stat,
   output logic [word_width-1:0] addr,
   output logic [word_width-1:0] data_out,
   input  logic [word_width-1:0] data_in
);
   import cpu_bus_pkg::*;

   localparam int                    CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [word_width-1:0] RD_MASK  = word_width'(1) << CTRL_RD;
   localparam logic [word_width-1:0] WR_MASK  = word_width'(1) << CTRL_WR;

   bus_state_e            r_state, w_state;
   logic [CNT_W-1:0]      r_cnt, w_cnt;
   logic                  r_we, w_we;
   logic                  r_req_ready, w_req_ready;
   logic                  r_resp_valid, w_resp_valid;
   logic [word_width-1:0] r_resp_rdata, w_resp_rdata;
   logic [1:0]            r_resp_err, w_resp_err;
   logic [word_width-1:0] r_mobo_ctrl, w_mobo_ctrl;
   logic [word_width-1:0] r_addr, w_addr;
   logic [word_width-1:0] r_data_out, w_data_out;

   logic w_ack;
   logic w_err;
   logic w_stat_unused;

   assign w_ack         = mobo_stat[STAT_ACK];
   assign w_err         = mobo_stat[STAT_ERR];
   assign w_stat_unused = ^mobo_stat[word_width-1:2];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= ERR_OK;
         r_mobo_ctrl  <= '0;
         r_addr       <= '0;
         r_data_out   <= '0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_we         <= w_we;
         r_req_ready  <= w_req_ready;
         r_resp_valid <= w_resp_valid;
         r_resp_rdata <= w_resp_rdata;
         r_resp_err   <= w_resp_err;
         r_mobo_ctrl  <= w_mobo_ctrl;
         r_addr       <= w_addr;
         r_data_out   <= w_data_out;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_we         = r_we;
      w_resp_valid = 1'b0;
      w_resp_rdata = r_resp_rdata;
      w_resp_err   = r_resp_err;
      w_mobo_ctrl  = r_mobo_ctrl;
      w_addr       = r_addr;
      w_data_out   = r_data_out;

      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state      = ST_STROBE;
               w_we         = req_we;
               w_addr       = req_addr;
               w_data_out   = req_wdata;
               w_mobo_ctrl  = req_we ? WR_MASK : RD_MASK;
               w_cnt        = '0;
               w_resp_rdata = '0;
               w_resp_err   = ERR_OK;
            end
         end
         ST_STROBE: begin
            if (w_ack) begin
               w_state     = ST_RELEASE;
               w_mobo_ctrl = '0;
               w_cnt       = '0;
               w_resp_err  = w_err ? ERR_BUS : ERR_OK;
               if (!r_we && !w_err) begin
                  w_resp_rdata = data_in;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_state      = ST_RESP;
               w_resp_valid = 1'b1;
               w_mobo_ctrl  = '0;
               w_resp_err   = ERR_TIMEOUT;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (!w_ack) begin
               w_state      = ST_RESP;
               w_resp_valid = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
               // Read data captured on ACK is discarded: errored responses carry zero.
               w_state      = ST_RESP;
               w_resp_valid = 1'b1;
               w_resp_err   = ERR_TIMEOUT;
               w_resp_rdata = '0;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_state = ST_IDLE;
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase

      w_req_ready = (w_state == ST_IDLE);
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign mobo_ctrl  = r_mobo_ctrl;
   assign addr       = r_addr;
   assign data_out   = r_data_out;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed bench for cpu_bus_unit: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every resp_valid.
module tb_cpu_bus_unit;
   import cpu_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] mobo_ctrl;
   logic [31:0] mobo_stat;
   logic [31:0] addr;
   logic [31:0] data_out;
   logic [31:0] data_in;

   cpu_bus_unit #(.word_width(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mobo_ctrl(mobo_ctrl), .mobo_stat(mobo_stat),
      .addr(addr), .data_out(data_out), .data_in(data_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Motherboard model: either directed status, or ACK that follows the strobe.
   logic        auto_ack = 1'b0;
   logic [31:0] man_stat = 32'd0;
   assign mobo_stat = auto_ack ? {30'd0, 1'b0, |mobo_ctrl[1:0]} : man_stat;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          at;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected no response", cyc);
         end else begin
            e = sb.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", {30'd0, resp_err}, {30'd0, e.err});
            check("resp_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   // Called at a negedge; returns at the negedge of the first strobe cycle.
   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input bit push, input logic [31:0] er, input logic [1:0] ee,
                        input int lat, output int acc);
      int k = 0;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      acc = cyc;
      if (req_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_wait: req_ready=%b after 20 cycles, expected 1", req_ready);
      end else if (push) begin
         sb.push_back('{er, ee, acc + lat});
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   int acc;
   int stable;
   int hi;
   int a1;
   int a2;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      data_in   = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_mobo_ctrl", mobo_ctrl, 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {30'd0, resp_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Read, ACK on the first strobe cycle.
      data_in = 32'hDEADBEEF;
      issue(1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF, ERR_OK, 3, acc);
      check("t1_strobe_rd", mobo_ctrl, 32'h1);
      check("t1_addr", addr, 32'h40);
      man_stat = 32'h1;
      @(negedge clk);
      check("t1_strobe_one_cycle", mobo_ctrl, 32'h0);
      man_stat = 32'h0;
      repeat (2) @(negedge clk);
      check("t1_ready_back", {31'd0, req_ready}, 32'd1);
      check("t1_rdata_held", resp_rdata, 32'hDEADBEEF);

      // Write, ACK after 5 strobe cycles.
      data_in = 32'hCAFEF00D;
      issue(1'b1, 32'h100, 32'h12345678, 1'b1, 32'h0, ERR_OK, 8, acc);
      stable = 0;
      for (int i = 0; i < 6; i++) begin
         if (mobo_ctrl === 32'h2 && addr === 32'h100 && data_out === 32'h12345678) stable++;
         if (i < 5) @(negedge clk);
      end
      check("t2_wr_stable_cycles", 32'(stable), 32'd6);
      man_stat = 32'h1;
      @(negedge clk);
      check("t2_strobe_dropped", mobo_ctrl, 32'h0);
      man_stat = 32'h0;
      repeat (2) @(negedge clk);

      // Read with no ACK: timeout.
      data_in = 32'h55AA55AA;
      issue(1'b0, 32'h200, 32'h0, 1'b1, 32'h0, ERR_TIMEOUT, 17, acc);
      hi = 0;
      while (mobo_ctrl[0] === 1'b1 && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      check("t3_strobe_cycles", 32'(hi), 32'd16);
      @(negedge clk);
      check("t3_ready_back", {31'd0, req_ready}, 32'd1);

      // Read with ACK+ERR.
      data_in = 32'h11112222;
      issue(1'b0, 32'h300, 32'h0, 1'b1, 32'h0, ERR_BUS, 3, acc);
      man_stat = 32'h3;
      @(negedge clk);
      man_stat = 32'h0;
      repeat (2) @(negedge clk);

      // ACK+ERR held through RELEASE: timeout overrides bus error.
      issue(1'b0, 32'h304, 32'h0, 1'b1, 32'h0, ERR_TIMEOUT, 18, acc);
      man_stat = 32'h3;
      repeat (17) @(negedge clk);
      man_stat = 32'h0;
      @(negedge clk);
      check("t4_ready_back", {31'd0, req_ready}, 32'd1);

      // Back-to-back reads with req_valid held.
      auto_ack  = 1'b1;
      data_in   = 32'h0BADF00D;
      req_we    = 1'b0;
      req_addr  = 32'h400;
      req_valid = 1'b1;
      a1 = -1;
      a2 = -1;
      for (int i = 0; i < 20 && a2 < 0; i++) begin
         if (req_ready === 1'b1) begin
            if (a1 < 0) a1 = cyc;
            else a2 = cyc;
            sb.push_back('{32'h0BADF00D, ERR_OK, cyc + 3});
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("t5_accept_spacing", 32'(a2 - a1), 32'd4);
      repeat (4) @(negedge clk);
      auto_ack = 1'b0;

      // ACK/ERR while idle must be ignored.
      man_stat = 32'h3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_idle_ack_ctrl", mobo_ctrl, 32'h0);
         check("t5_idle_ack_ready", {31'd0, req_ready}, 32'd1);
      end
      man_stat = 32'h0;
      @(negedge clk);
      auto_ack = 1'b1;
      issue(1'b1, 32'h500, 32'hA5A5A5A5, 1'b1, 32'h0, ERR_OK, 3, acc);
      repeat (3) @(negedge clk);
      auto_ack = 1'b0;

      // Reset during STROBE: strobe drops, no response.
      issue(1'b0, 32'h600, 32'h0, 1'b0, 32'h0, ERR_OK, 0, acc);
      check("t6_strobe_before_rst", mobo_ctrl, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_ctrl_after_rst", mobo_ctrl, 32'h0);
      check("t6_ready_in_rst", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("t6_ready_after_rst", {31'd0, req_ready}, 32'd1);

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish by 100000 ns, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
